// File: rtl/uart_frame_assembler.sv
// Byte-to-word assembler: detects a sync run, packs bytes MSB-first into BYTES-wide words,
// closes the frame on an all-END word, and reports inter-byte timeouts and dropped words.
module uart_frame_assembler #(
   parameter int unsigned BYTES          = 8,
   parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
   parameter logic [7:0]  END_BYTE       = 8'h55,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               rx_valid_i,
   input  logic [7:0]         rx_data_i,
   input  logic               word_ready_i,
   output logic [8*BYTES-1:0] word_data_o,
   output logic               word_valid_o,
   output logic               active_o,
   output logic               frame_end_o,
   output logic               err_timeout_o,
   output logic               err_overflow_o
);

   localparam int unsigned W     = 8 * BYTES;
   localparam int unsigned CNT_W = $clog2(BYTES);
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [W-1:0]     SYNC_WORD = {BYTES{SYNC_BYTE}};
   localparam logic [W-1:0]     END_WORD  = {BYTES{END_BYTE}};
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_e;

   state_e           state_q;
   // Only BYTES-1 bytes need storing: the newest byte comes straight from rx_data_i.
   logic [W-9:0]     shift_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [TMO_W-1:0] tmo_q;
   logic [W-1:0]     word_data_q;
   logic             word_valid_q;
   logic             active_q;
   logic             frame_end_q;
   logic             err_timeout_q;
   logic             err_overflow_q;
   logic [W-1:0]     shift_d;

   assign shift_d = {shift_q, rx_data_i};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= ST_IDLE;
         shift_q        <= '0;
         byte_cnt_q     <= '0;
         tmo_q          <= '0;
         word_data_q    <= '0;
         word_valid_q   <= 1'b0;
         active_q       <= 1'b0;
         frame_end_q    <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         frame_end_q    <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         if (word_ready_i) begin
            word_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (rx_valid_i) begin
                  if (shift_d == SYNC_WORD) begin
                     state_q    <= ST_ACTIVE;
                     active_q   <= 1'b1;
                     shift_q    <= '0;
                     byte_cnt_q <= '0;
                     tmo_q      <= '0;
                  end else begin
                     shift_q <= shift_d[W-9:0];
                  end
               end
            end

            ST_ACTIVE: begin
               if (rx_valid_i) begin
                  shift_q <= shift_d[W-9:0];
                  tmo_q   <= '0;
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_q <= '0;
                     if (shift_d == END_WORD) begin
                        state_q     <= ST_IDLE;
                        active_q    <= 1'b0;
                        frame_end_q <= 1'b1;
                     end else if (!word_valid_q || word_ready_i) begin
                        word_data_q  <= shift_d;
                        word_valid_q <= 1'b1;
                     end else begin
                        err_overflow_q <= 1'b1;
                     end
                  end else begin
                     byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                  end
               end else if (TIMEOUT_CYCLES != 0 && byte_cnt_q != '0) begin
                  // Partial word idle too long: discard it but stay in the frame.
                  if (tmo_q == TMO_LAST) begin
                     byte_cnt_q    <= '0;
                     tmo_q         <= '0;
                     shift_q       <= '0;
                     err_timeout_q <= 1'b1;
                  end else begin
                     tmo_q <= tmo_q + TMO_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign word_data_o    = word_data_q;
   assign word_valid_o   = word_valid_q;
   assign active_o       = active_q;
   assign frame_end_o    = frame_end_q;
   assign err_timeout_o  = err_timeout_q;
   assign err_overflow_o = err_overflow_q;

endmodule
